imm_instr_encoder: RTL and testbench

- Inverse of the core's immediate decode path: packs a format code, register and funct fields, and a 32-bit immediate into an RV32I instruction word.
- Range-checks the immediate for the chosen format and buffers results in a small in-order FIFO with valid/ready on both sides.
- Sits between the debug/boot instruction-injection logic and the per-core instruction feed of the multicore system.

---
 rtl/imm_enc_pkg.sv | 39 +++
 rtl/imm_instr_encoder_enc_fifo.sv | 60 ++++++
 rtl/imm_instr_encoder.sv | 116 +++++++++++
 tb/tb_imm_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the RV32I immediate-instruction encoder.
package imm_enc_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_SHIFT = 3'd1,
    FMT_LOAD  = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_INV   = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  // One FIFO entry: encoded word plus its range/alignment error flag.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // True when v, read as two's complement, lies within [lo, hi].
  function automatic logic in_srange(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_instr_encoder_enc_fifo.sv
// Generic in-order synchronous FIFO; head word is read from registered storage.
module enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; each advances only on an effective push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
  end

  // Pointer registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the visible head reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Packs format/register/funct fields and an immediate into an RV32I word,
// flags out-of-range immediates and buffers results in an in-order FIFO.
module imm_instr_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic [INSTR_W-1:0] enc_instr;
  logic               enc_err;
  entry_t             wr_entry, rd_entry;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // Combinational encoder and range/alignment checker for the incoming request.
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
        enc_err   = !in_srange(in_imm, -2048, 2047);
      end
      FMT_SHIFT: begin
        enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
        enc_err   = (in_imm > 32'd31);
      end
      FMT_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_err   = !in_srange(in_imm, -2048, 2047);
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_err   = !in_srange(in_imm, -2048, 2047);
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_err   = !in_srange(in_imm, -4096, 4094) || in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, OP_LUI};
        enc_err   = (in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_err   = !in_srange(in_imm, -1048576, 1048574) || in_imm[0];
      end
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  assign wr_entry = {enc_instr, enc_err};
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign out_instr = rd_entry.instr;
  assign out_err   = rd_entry.err;
  assign err_count = err_cnt_q;

  // Saturating error count, bumped when an erroneous request is accepted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: expected words pushed on accept, popped on output.
module tb_imm_instr_encoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  imm_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding: {instr, err}
  function automatic logic [32:0] model(input logic [2:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    logic [31:0] w;
    logic e;
    int s;
    s = $signed(imm);
    w = 32'h0000_0013;
    e = 1'b1;
    case (f)
      3'd0: begin w = {imm[11:0], rs1, f3, rd, 7'h13}; e = (s < -2048) || (s > 2047); end
      3'd1: begin w = {f7, imm[4:0], rs1, f3, rd, 7'h13}; e = (imm > 32'd31); end
      3'd2: begin w = {imm[11:0], rs1, f3, rd, 7'h03}; e = (s < -2048) || (s > 2047); end
      3'd3: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; e = (s < -2048) || (s > 2047); end
      3'd4: begin
        w = '0;
        w[31] = imm[12]; w[30:25] = imm[10:5]; w[24:20] = rs2; w[19:15] = rs1;
        w[14:12] = f3; w[11:8] = imm[4:1]; w[7] = imm[11]; w[6:0] = 7'h63;
        e = (s < -4096) || (s > 4094) || imm[0];
      end
      3'd5: begin w = {imm[31:12], rd, 7'h37}; e = (imm[11:0] != 12'd0); end
      3'd6: begin
        w = '0;
        w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
        w[11:7] = rd; w[6:0] = 7'h6F;
        e = (s < -1048576) || (s > 1048574) || imm[0];
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {w, e};
  endfunction

  task automatic set_req(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called at a falling edge: account for the handshakes of the coming rising edge.
  task automatic cycle();
    logic [32:0] e;
    if (out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output got instr=%h err=%b with empty scoreboard", out_instr, out_err);
      end else begin
        e = sb_q.pop_front();
        if ({out_instr, out_err} !== e) begin
          errors++;
          $display("FAIL sb_entry got instr=%h err=%b expected instr=%h err=%b",
                   out_instr, out_err, e[32:1], e[0]);
        end
      end
    end
    if (in_valid && in_ready) begin
      e = model(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      sb_q.push_back(e);
      if (e[0] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain left=%0d out_valid=%b expected left=0 out_valid=0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_instr, out_err, err_count} !== {1'b0, 32'h0, 1'b0, {CNT_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state got v=%b instr=%h err=%b cnt=%0d expected 0 0 0 0",
               out_valid, out_instr, out_err, err_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_imm_i();
    out_ready = 1'b1;
    set_req(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_err} !== {1'b1, 32'hFFF0_0093, 1'b0}) begin
      errors++;
      $display("FAIL imm_i_latency got v=%b instr=%h err=%b expected v=1 instr=fff00093 err=0",
               out_valid, out_instr, out_err);
    end
    drain();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    set_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({out_instr, out_err} !== {32'hFE20_8EE3, 1'b0}) begin
      errors++;
      $display("FAIL branch_neg4 got instr=%h err=%b expected fe208ee3 0", out_instr, out_err);
    end
    cycle();
    set_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({out_err, err_count} !== {1'b1, CNT_W'(1)}) begin
      errors++;
      $display("FAIL branch_misaligned got err=%b cnt=%0d expected err=1 cnt=1", out_err, err_count);
    end
    drain();
  endtask

  task automatic test_shift();
    out_ready = 1'b1;
    set_req(3'd1, 5'd5, 5'd5, 5'd0, 3'd5, 7'b0100000, 32'd3);
    cycle();
    set_req(3'd1, 5'd5, 5'd5, 5'd0, 3'd5, 7'b0100000, 32'd32);
    checks++;
    if ({out_instr, out_err} !== {32'h4032_D293, 1'b0}) begin
      errors++;
      $display("FAIL shift_srai got instr=%h err=%b expected 4032d293 0", out_instr, out_err);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_err !== 1'b1) begin
      errors++;
      $display("FAIL shift_range got err=%b expected 1", out_err);
    end
    drain();
  endtask

  task automatic test_jal_invalid();
    out_ready = 1'b1;
    set_req(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    cycle();
    set_req(3'd7, 5'd3, 5'd4, 5'd5, 3'd2, 7'd9, 32'd0);
    checks++;
    if ({out_instr, out_err} !== {32'h0010_00EF, 1'b0}) begin
      errors++;
      $display("FAIL jal_2048 got instr=%h err=%b expected 001000ef 0", out_instr, out_err);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({out_instr, out_err} !== {32'h0000_0013, 1'b1}) begin
      errors++;
      $display("FAIL fmt_invalid got instr=%h err=%b expected 00000013 1", out_instr, out_err);
    end
    drain();
    checks++;
    if (err_count !== exp_cnt) begin
      errors++;
      $display("FAIL err_count got %0d expected %0d", err_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] head;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(3'd2, 5'(i + 1), 5'd2, 5'd0, 3'd2, 7'd0, 32'(i * 4));
      cycle();
    end
    set_req(3'd3, 5'd0, 5'd7, 5'd8, 3'd1, 7'd0, 32'd100);
    head = sb_q[0][32:1];
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({in_ready, out_valid, out_instr} !== {1'b0, 1'b1, head}) begin
        errors++;
        $display("FAIL full_hold got rdy=%b v=%b instr=%h expected rdy=0 v=1 instr=%h",
                 in_ready, out_valid, out_instr, head);
      end
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      set_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), (i % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      cycle();
      checks++;
      if ({in_ready, out_valid} !== 2'b11 || sb_q.size() != 1) begin
        errors++;
        $display("FAIL steady_occupancy got rdy=%b v=%b depth=%0d expected rdy=1 v=1 depth=1",
                 in_ready, out_valid, sb_q.size());
      end
    end
    drain();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      cycle();
    end
    drain();
    checks++;
    if (err_count !== exp_cnt || err_count !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL err_saturate got %0d expected %0d", err_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_req(3'd0, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd7);
    cycle();
    set_req(3'd5, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_instr, err_count} !== {1'b0, 32'h0, {CNT_W{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset got v=%b instr=%h cnt=%0d expected 0 0 0", out_valid, out_instr, err_count);
    end
    sb_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    set_req(3'd3, 5'd0, 5'd10, 5'd11, 3'd2, 7'd0, 32'hFFFF_F800);
    cycle();
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_imm_i();
    test_branch();
    test_shift();
    test_jal_invalid();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
